// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the PC, fetches from a combinational ROM into IF/ID and flags out-of-range fetches.
// Optional FETCH_PERF_CNT_EN builds fetch/stall performance counters; otherwise both read 0.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ROM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        fetch_fault,
  output logic [1:0]  fsm_state,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);
  typedef enum logic [1:0] {RUN = 2'b00, HALT = 2'b01, FAULT = 2'b10} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pc4;
  logic fetch, hold, oor, run;
  assign pc4 = pc + 32'd4;
  assign rom_addr = pc;
  assign fsm_state = state;
  assign fetch_fault = state == FAULT;
  assign oor = (pc >> 2) >= 32'(ROM_WORDS);
  // Dropping halt_req in HALT resumes fetching on that same edge from the held pc.
  assign run = state == RUN || (state == HALT && !halt_req);
  always_comb begin
    state_n = state;
    pc_n = pc;
    fetch = 1'b0;
    hold = 1'b0;
    if (redirect_valid) begin
      pc_n = redirect_pc & 32'hFFFF_FFFC;
      state_n = (state == HALT && halt_req) ? HALT : RUN;
    end else if (run) begin
      state_n = RUN;
      if (stall) hold = !flush;
      else if (halt_req) state_n = HALT;
      else if (oor) state_n = FAULT;
      else begin
        pc_n = pc4;
        fetch = !flush;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc <= RESET_PC;
      if_instr <= '0;
      if_pc <= '0;
      if_pc4 <= '0;
      if_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if (fetch) begin
        if_instr <= rom_data;
        if_pc <= pc;
        if_pc4 <= pc4;
        if_valid <= 1'b1;
      end else if (!hold) begin
        if_instr <= '0;
        if_valid <= 1'b0;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt, scnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      scnt <= '0;
    end else begin
      if (fetch) fcnt <= fcnt + 32'd1;
      if (state == RUN && stall && !redirect_valid) scnt <= scnt + 32'd1;
    end
  end
  assign fetch_count = fcnt;
  assign stall_count = scnt;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed stimulus pushes expected IF/ID words into a queue; a negedge monitor pops and compares.
module tb_imem_fetch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] rom_addr, rom_data, redirect_pc = '0;
  logic stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0;
  logic [31:0] if_instr, if_pc, if_pc4, fetch_count, stall_count;
  logic if_valid, fetch_fault;
  logic [1:0] fsm_state;
  int checks = 0, errors = 0;
  typedef struct packed {logic [31:0] i, p, p4;} ent_t;
  ent_t q[$];

  imem_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4), .if_valid(if_valid),
    .fetch_fault(fetch_fault), .fsm_state(fsm_state), .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {25'b0, a[8:2]} * 32'h0001_0003;
  endfunction
  assign rom_data = rom_word(rom_addr);

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask

  // Inputs are applied just after a negedge; the expected IF/ID (if any) is popped at the next negedge.
  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rp,
                       input logic h, input logic ev, input logic [31:0] epc);
    stall = s; flush = f; redirect_valid = r; redirect_pc = rp; halt_req = h;
    if (ev) q.push_back('{rom_word(epc), epc, epc + 32'd4});
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && if_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fetch got pc %h want none", if_pc);
      end else begin
        ent_t e;
        e = q.pop_front();
        if ({if_instr, if_pc, if_pc4} !== e) begin
          errors++;
          $display("FAIL ifid got %h/%h/%h want %h/%h/%h", if_instr, if_pc, if_pc4, e.i, e.p, e.p4);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_addr", rom_addr, 32'd0);
    chk("rst_state", {30'b0, fsm_state}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 32'(i * 4));
    chk("addr_e3", rom_addr, 32'h0C);
    chk("pc4_e3", if_pc4, 32'h0C);
    drive(0, 0, 0, 0, 0, 1, 32'h0C);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 1, 32'h0C);
      chk("stall_addr", rom_addr, 32'h10);
    end
    drive(0, 0, 0, 0, 0, 1, 32'h10);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("stflush_addr", rom_addr, 32'h14);
    chk("stflush_valid", {31'b0, if_valid}, 32'd0);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("flush_addr", rom_addr, 32'h18);
    drive(1, 0, 1, 32'h12E, 0, 0, 0);
    chk("redir_addr", rom_addr, 32'h12C);
    chk("redir_valid", {31'b0, if_valid}, 32'd0);
    drive(0, 0, 0, 0, 0, 1, 32'h12C);
    drive(0, 0, 1, 32'h40, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("halt_state", {30'b0, fsm_state}, 32'd1);
      chk("halt_addr", rom_addr, 32'h40);
      chk("halt_valid", {31'b0, if_valid}, 32'd0);
    end
    drive(0, 0, 0, 0, 0, 1, 32'h40);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 32'h1F0, 1, 0, 0);
    chk("halt_redir_state", {30'b0, fsm_state}, 32'd1);
    chk("halt_redir_addr", rom_addr, 32'h1F0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 32'(32'h1F0 + i * 4));
    chk("edge_addr", rom_addr, 32'h200);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fault_flag", {31'b0, fetch_fault}, 32'd1);
    chk("fault_state", {30'b0, fsm_state}, 32'd2);
    chk("fault_valid", {31'b0, if_valid}, 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fault_hold_state", {30'b0, fsm_state}, 32'd2);
    chk("fault_hold_addr", rom_addr, 32'h200);
    chk("fault_hold_flag", {31'b0, fetch_fault}, 32'd1);
    drive(0, 0, 1, 32'h0, 0, 0, 0);
    chk("unfault_state", {30'b0, fsm_state}, 32'd0);
    chk("unfault_flag", {31'b0, fetch_fault}, 32'd0);
    chk("unfault_addr", rom_addr, 32'h0);
    drive(0, 0, 0, 0, 0, 1, 32'h0);
    chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, 32'd12);
    chk("stall_count", stall_count, 32'd3);
`else
    chk("fetch_count", fetch_count, 32'd0);
    chk("stall_count", stall_count, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
